// File: rtl/regfile_sequencer.sv
// Multi-cycle instruction sequencer driving an external register file through
// one combinational read port and one write port.
//
// state  | meaning
// IDLE   | ready; accepts an instruction
// READ_A | drive rs1 on the read port, capture operand A
// READ_B | drive rs2 on the read port, capture operand B
// WRITE  | drive the result to rd, pulse done, register result and flags
module regfile_sequencer #(
    parameter int N_REGS     = 8,
    parameter int REG_WIDTH  = 8,
    parameter int ADDR_WIDTH = $clog2(N_REGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_op,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    input  logic [ADDR_WIDTH-1:0] in_rs1,
    input  logic [ADDR_WIDTH-1:0] in_rs2,
    input  logic [REG_WIDTH-1:0]  in_imm,
    output logic [ADDR_WIDTH-1:0] rf_rreg_index,
    input  logic [REG_WIDTH-1:0]  rf_data_out,
    output logic [ADDR_WIDTH-1:0] rf_wreg_index,
    output logic [REG_WIDTH-1:0]  rf_data_in,
    output logic                  rf_write_enable,
    output logic                  done,
    output logic [REG_WIDTH-1:0]  result,
    output logic                  flag_z,
    output logic                  flag_c
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ_A = 2'd1,
        READ_B = 2'd2,
        WRITE  = 2'd3
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_MOV = 3'b101;
    localparam logic [2:0] OP_LDI = 3'b110;
    localparam logic [2:0] OP_CMP = 3'b111;

    state_t                state;
    state_t                state_next;
    logic [2:0]            op_q;
    logic [ADDR_WIDTH-1:0] rd_q;
    logic [ADDR_WIDTH-1:0] rs1_q;
    logic [ADDR_WIDTH-1:0] rs2_q;
    logic [REG_WIDTH-1:0]  imm_q;
    logic [REG_WIDTH-1:0]  a_q;
    logic [REG_WIDTH-1:0]  b_q;

    logic                  accept;
    logic [REG_WIDTH:0]    sum;
    logic [REG_WIDTH-1:0]  diff;
    logic [REG_WIDTH-1:0]  alu_result;
    logic                  alu_z;
    logic                  alu_c;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            op_q   <= '0;
            rd_q   <= '0;
            rs1_q  <= '0;
            rs2_q  <= '0;
            imm_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            result <= '0;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                op_q  <= in_op;
                rd_q  <= in_rd;
                rs1_q <= in_rs1;
                rs2_q <= in_rs2;
                imm_q <= in_imm;
            end
            if (state == READ_A) a_q <= rf_data_out;
            if (state == READ_B) b_q <= rf_data_out;
            if (state == WRITE) begin
                result <= alu_result;
                flag_z <= alu_z;
                flag_c <= alu_c;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = (in_op == OP_LDI) ? WRITE : READ_A;
            READ_A:  state_next = (op_q == OP_MOV) ? WRITE : READ_B;
            READ_B:  state_next = WRITE;
            WRITE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        sum        = {1'b0, a_q} + {1'b0, b_q};
        diff       = a_q - b_q;
        alu_result = '0;
        alu_c      = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_result = sum[REG_WIDTH-1:0];
                alu_c      = sum[REG_WIDTH];
            end
            OP_SUB, OP_CMP: begin
                alu_result = diff;
                alu_c      = (a_q < b_q);
            end
            OP_AND:  alu_result = a_q & b_q;
            OP_OR:   alu_result = a_q | b_q;
            OP_XOR:  alu_result = a_q ^ b_q;
            OP_MOV:  alu_result = a_q;
            OP_LDI:  alu_result = imm_q;
            default: alu_result = '0;
        endcase
        alu_z = (alu_result == '0);
    end

    always_comb begin
        rf_rreg_index   = '0;
        rf_wreg_index   = '0;
        rf_data_in      = '0;
        rf_write_enable = 1'b0;
        done            = 1'b0;
        case (state)
            READ_A: rf_rreg_index = rs1_q;
            READ_B: rf_rreg_index = rs2_q;
            WRITE: begin
                rf_wreg_index = rd_q;
                rf_data_in    = alu_result;
                // Reset must suppress the write at the very edge it aborts.
                rf_write_enable = (op_q != OP_CMP) && !reset;
                done            = !reset;
            end
            default: rf_rreg_index = '0;
        endcase
    end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: behavioural register file, scoreboard of
// expected completions, directed scenarios plus a short random stream.
module tb_regfile_sequencer;

    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011;
    localparam logic [2:0] XOR_ = 3'b100, MOV = 3'b101, LDI = 3'b110, CMP = 3'b111;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_op, in_rd, in_rs1, in_rs2;
    logic [7:0] in_imm;
    logic [2:0] rf_rreg_index, rf_wreg_index;
    logic [7:0] rf_data_out, rf_data_in;
    logic       rf_write_enable, done, flag_z, flag_c;
    logic [7:0] result;

    logic [7:0] regs [8];

    typedef struct {
        int         lat;
        logic       wen;
        logic [2:0] idx;
        logic [7:0] data;
        logic       z;
        logic       c;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    regfile_sequencer dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .rf_rreg_index(rf_rreg_index), .rf_data_out(rf_data_out),
        .rf_wreg_index(rf_wreg_index), .rf_data_in(rf_data_in),
        .rf_write_enable(rf_write_enable), .done(done), .result(result),
        .flag_z(flag_z), .flag_c(flag_c)
    );

    assign rf_data_out = regs[rf_rreg_index];
    always @(posedge clk) if (rf_write_enable) regs[rf_wreg_index] <= rf_data_in;

    function automatic exp_t model(input logic [2:0] op, input logic [2:0] rd,
                                   input logic [7:0] a, input logic [7:0] b,
                                   input logic [7:0] imm);
        exp_t e;
        logic [8:0] s;
        e.lat = 3; e.wen = 1'b1; e.idx = rd; e.c = 1'b0; e.data = 8'h00;
        case (op)
            ADD:  begin s = {1'b0, a} + {1'b0, b}; e.data = s[7:0]; e.c = s[8]; end
            SUB:  begin e.data = a - b; e.c = (a < b); end
            CMP:  begin e.data = a - b; e.c = (a < b); e.wen = 1'b0; end
            AND_: e.data = a & b;
            OR_:  e.data = a | b;
            XOR_: e.data = a ^ b;
            MOV:  begin e.data = a; e.lat = 2; end
            default: begin e.data = imm; e.lat = 1; end
        endcase
        e.z = (e.data == 8'h00);
        return e;
    endfunction

    task automatic wait_ready(input string name);
        int waited = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s ready_timeout in_ready=%b required 1", name, in_ready);
        end
    endtask

    task automatic drive_accept(input logic [2:0] op, rd, rs1, rs2, input logic [7:0] imm);
        in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_op = 3'($urandom); in_rd = 3'($urandom);
        in_rs1 = 3'($urandom); in_rs2 = 3'($urandom); in_imm = 8'($urandom);
    endtask

    task automatic run_instr(input logic [2:0] op, rd, rs1, rs2, input logic [7:0] imm);
        exp_t e;
        int   lat = 0;
        exp_q.push_back(model(op, rd, regs[rs1], regs[rs2], imm));
        wait_ready("run_instr");
        drive_accept(op, rd, rs1, rs2, imm);
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            @(negedge clk);
            if (done === 1'b1) lat = k;
            else if (k == 1 && op != LDI) begin
                tests_run++;
                if (rf_rreg_index !== rs1) begin
                    tests_failed++;
                    $display("FAIL read_rs1 op=%0d idx=%0d required %0d", op, rf_rreg_index, rs1);
                end
            end else if (k == 2) begin
                tests_run++;
                if (rf_rreg_index !== rs2) begin
                    tests_failed++;
                    $display("FAIL read_rs2 op=%0d idx=%0d required %0d", op, rf_rreg_index, rs2);
                end
            end
        end
        e = exp_q.pop_front();
        tests_run++;
        if (lat != e.lat) begin
            tests_failed++;
            $display("FAIL latency op=%0d got %0d required %0d", op, lat, e.lat);
        end
        if (lat == 0) return;
        tests_run++;
        if (rf_write_enable !== e.wen || rf_wreg_index !== e.idx || rf_data_in !== e.data ||
            rf_rreg_index !== 3'd0) begin
            tests_failed++;
            $display("FAIL write_port op=%0d we=%b idx=%0d data=%h ridx=%0d required we=%b idx=%0d data=%h ridx=0",
                     op, rf_write_enable, rf_wreg_index, rf_data_in, rf_rreg_index, e.wen, e.idx, e.data);
        end
        @(negedge clk);
        tests_run++;
        if (result !== e.data || flag_z !== e.z || flag_c !== e.c || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL result_flags op=%0d res=%h z=%b c=%b done=%b required res=%h z=%b c=%b done=0",
                     op, result, flag_z, flag_c, done, e.data, e.z, e.c);
        end
    endtask

    task automatic check_reg(input string name, input int r, input logic [7:0] v);
        tests_run++;
        if (regs[r] !== v) begin
            tests_failed++;
            $display("FAIL %s r%0d=%h required %h", name, r, regs[r], v);
        end
    endtask

    task automatic test_reset();
        in_valid = 1'b1; in_op = LDI; in_rd = 3'd1; in_rs1 = 3'd0; in_rs2 = 3'd0; in_imm = 8'h5A;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if (done !== 1'b0 || rf_write_enable !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_hold done=%b we=%b rdy=%b required 0 0 1", done, rf_write_enable, in_ready);
        end
        in_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b1 || result !== 8'h00 || flag_z !== 1'b0 || flag_c !== 1'b0 ||
            rf_rreg_index !== 3'd0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state rdy=%b res=%h z=%b c=%b ridx=%0d done=%b required 1 00 0 0 0 0",
                     in_ready, result, flag_z, flag_c, rf_rreg_index, done);
        end
    endtask

    task automatic test_preload();
        for (int r = 0; r < 8; r++) run_instr(LDI, 3'(r), 3'd0, 3'd0, 8'(8'h10 * r + r));
        for (int r = 0; r < 8; r++) check_reg("preload", r, 8'(8'h10 * r + r));
    endtask

    task automatic test_add();
        run_instr(LDI, 3'd1, 3'd0, 3'd0, 8'h7F);
        run_instr(LDI, 3'd2, 3'd0, 3'd0, 8'h81);
        run_instr(ADD, 3'd3, 3'd1, 3'd2, 8'h00);
        check_reg("add", 3, 8'h00);
        tests_run++;
        if (flag_z !== 1'b1 || flag_c !== 1'b1) begin
            tests_failed++;
            $display("FAIL add_flags z=%b c=%b required 1 1", flag_z, flag_c);
        end
    endtask

    task automatic test_sub_cmp();
        logic [7:0] r0_old;
        run_instr(LDI, 3'd1, 3'd0, 3'd0, 8'h05);
        run_instr(LDI, 3'd2, 3'd0, 3'd0, 8'h07);
        run_instr(SUB, 3'd4, 3'd1, 3'd2, 8'h00);
        check_reg("sub", 4, 8'hFE);
        tests_run++;
        if (flag_c !== 1'b1 || flag_z !== 1'b0) begin
            tests_failed++;
            $display("FAIL sub_flags z=%b c=%b required 0 1", flag_z, flag_c);
        end
        r0_old = regs[0];
        run_instr(CMP, 3'd0, 3'd2, 3'd2, 8'h00);
        check_reg("cmp_nowrite", 0, r0_old);
        tests_run++;
        if (flag_z !== 1'b1 || flag_c !== 1'b0 || result !== 8'h00) begin
            tests_failed++;
            $display("FAIL cmp_flags z=%b c=%b res=%h required 1 0 00", flag_z, flag_c, result);
        end
    endtask

    task automatic test_ldi_mov();
        run_instr(LDI, 3'd5, 3'd0, 3'd0, 8'hA5);
        check_reg("ldi", 5, 8'hA5);
        run_instr(MOV, 3'd6, 3'd5, 3'd3, 8'h00);
        check_reg("mov", 6, 8'hA5);
    endtask

    task automatic test_alias();
        run_instr(LDI, 3'd2, 3'd0, 3'd0, 8'h0F);
        run_instr(XOR_, 3'd2, 3'd2, 3'd2, 8'h00);
        check_reg("alias_xor", 2, 8'h00);
        tests_run++;
        if (flag_z !== 1'b1) begin
            tests_failed++;
            $display("FAIL alias_flag z=%b required 1", flag_z);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) run_instr(LDI, 3'(r), 3'd0, 3'd0, 8'($urandom));
        for (int i = 0; i < 12; i++)
            run_instr(3'($urandom_range(0, 7)), 3'($urandom), 3'($urandom), 3'($urandom), 8'($urandom));
    endtask

    task automatic test_back_to_back();
        logic [2:0] rds [3] = '{3'd4, 3'd5, 3'd6};
        logic [2:0] ras [3] = '{3'd1, 3'd1, 3'd2};
        logic [2:0] rbs [3] = '{3'd2, 3'd3, 3'd3};
        int   n = 0;
        int   dones = 0;
        exp_t e;
        run_instr(LDI, 3'd1, 3'd0, 3'd0, 8'h10);
        run_instr(LDI, 3'd2, 3'd0, 3'd0, 8'h20);
        run_instr(LDI, 3'd3, 3'd0, 3'd0, 8'hF0);
        for (int i = 0; i < 3; i++) exp_q.push_back(model(ADD, rds[i], regs[ras[i]], regs[rbs[i]], 8'h00));
        @(negedge clk);
        in_op = ADD; in_rd = rds[0]; in_rs1 = ras[0]; in_rs2 = rbs[0]; in_imm = 8'h00;
        in_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            tests_run++;
            if (in_ready !== (c % 4 == 0) || done !== (c % 4 == 3)) begin
                tests_failed++;
                $display("FAIL b2b_cycle c=%0d rdy=%b done=%b required %b %b",
                         c, in_ready, done, (c % 4 == 0), (c % 4 == 3));
            end
            if (done === 1'b1 && exp_q.size() > 0) begin
                dones++;
                e = exp_q.pop_front();
                tests_run++;
                if (rf_write_enable !== 1'b1 || rf_wreg_index !== e.idx || rf_data_in !== e.data) begin
                    tests_failed++;
                    $display("FAIL b2b_write we=%b idx=%0d data=%h required 1 %0d %h",
                             rf_write_enable, rf_wreg_index, rf_data_in, e.idx, e.data);
                end
            end
            if (in_ready === 1'b1 && in_valid) n++;
            if (c % 4 == 1) begin
                if (n < 3) begin
                    in_rd = rds[n]; in_rs1 = ras[n]; in_rs2 = rbs[n];
                end else in_valid = 1'b0;
            end
        end
        @(negedge clk);
        tests_run++;
        if (n != 3 || dones != 3 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_count accepts=%0d dones=%0d rdy=%b required 3 3 1", n, dones, in_ready);
        end
        check_reg("b2b_r4", 4, 8'h30);
        check_reg("b2b_r5", 5, 8'h00);
        check_reg("b2b_r6", 6, 8'h10);
        exp_q.delete();
    endtask

    task automatic test_reset_abort();
        int bad = 0;
        run_instr(LDI, 3'd7, 3'd0, 3'd0, 8'h33);
        run_instr(LDI, 3'd1, 3'd0, 3'd0, 8'h11);
        run_instr(LDI, 3'd2, 3'd0, 3'd0, 8'h82);
        wait_ready("abort_b");
        drive_accept(ADD, 3'd7, 3'd1, 3'd2, 8'h00);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        tests_run++;
        if (in_ready !== 1'b1 || result !== 8'h00 || flag_z !== 1'b0 || flag_c !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_state rdy=%b res=%h z=%b c=%b required 1 00 0 0",
                     in_ready, result, flag_z, flag_c);
        end
        for (int k = 0; k < 4; k++) begin
            if (done !== 1'b0 || rf_write_enable !== 1'b0) bad++;
            @(negedge clk);
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL abort_quiet pulses=%0d required 0", bad);
        end
        check_reg("abort_r7", 7, 8'h33);

        wait_ready("abort_w");
        drive_accept(LDI, 3'd7, 3'd0, 3'd0, 8'h99);
        @(negedge clk);
        tests_run++;
        if (done !== 1'b1) begin
            tests_failed++;
            $display("FAIL abort_w_reach done=%b required 1", done);
        end
        reset = 1'b1;
        #1;
        tests_run++;
        if (done !== 1'b0 || rf_write_enable !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_w_gate done=%b we=%b required 0 0", done, rf_write_enable);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_reg("abort_w_r7", 7, 8'h33);
        tests_run++;
        if (done !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL abort_w_after done=%b rdy=%b required 0 1", done, in_ready);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0;
        in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
        test_reset();
        test_preload();
        test_add();
        test_sub_cmp();
        test_ldi_mov();
        test_alias();
        test_back_to_back();
        test_random();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/regfile_sequencer.md
REGFILE_SEQUENCER -- requirements
Module: regfile_sequencer

Interface
REQ-001 SHALL have parameters: N_REGS, default 8, number of registers; REG_WIDTH, default 8, data width; ADDR_WIDTH, default $clog2(N_REGS), register index width.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1, instruction offered.
REQ-005 SHALL have port in_ready, output, 1, instruction accepted when in_valid and in_ready are both high at a rising edge.
REQ-006 SHALL have ports in_op (input, 3), in_rd, in_rs1 and in_rs2 (input, ADDR_WIDTH each), and in_imm (input, REG_WIDTH): the instruction fields.
REQ-007 SHALL have ports rf_rreg_index (output, ADDR_WIDTH) and rf_data_out (input, REG_WIDTH): the register file read port, which is combinational.
REQ-008 SHALL have ports rf_wreg_index (output, ADDR_WIDTH), rf_data_in (output, REG_WIDTH) and rf_write_enable (output, 1): the register file write port.
REQ-009 SHALL have ports done (output, 1, one-cycle completion pulse), result (output, REG_WIDTH, last computed value), flag_z (output, 1, zero) and flag_c (output, 1, carry/borrow).

Function
REQ-010 SHALL implement the states IDLE, READ_A, READ_B and WRITE in a registered state machine.
REQ-011 in_ready SHALL equal (state == IDLE); an accept SHALL latch op, rd, rs1, rs2 and imm into internal registers.
REQ-012 Opcodes SHALL be: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 MOV (rd=rs1), 110 LDI (rd=imm), 111 CMP (rs1-rs2, flags only, no write).
REQ-013 Transitions SHALL be: IDLE->READ_A on accept, except LDI, which goes IDLE->WRITE; READ_A->READ_B, except MOV, which goes READ_A->WRITE; READ_B->WRITE; WRITE->IDLE.
REQ-014 In READ_A, rf_rreg_index SHALL be rs1 and operand A SHALL be captured from rf_data_out at the cycle end.
REQ-015 In READ_B, rf_rreg_index SHALL be rs2 and operand B SHALL be captured likewise.
REQ-016 In all other states, rf_rreg_index SHALL be 0.
REQ-017 In WRITE, rf_write_enable SHALL be 1 (0 for CMP), rf_wreg_index SHALL be rd and rf_data_in SHALL be the combinational result.
REQ-018 Outside WRITE, rf_write_enable, rf_wreg_index and rf_data_in SHALL be 0.
REQ-019 done SHALL be 1 exactly during the WRITE cycle.
REQ-020 result, flag_z and flag_c SHALL be registered at the end of WRITE and held until the next WRITE.
REQ-021 Arithmetic SHALL be modulo 2^REG_WIDTH.
REQ-022 For ADD, flag_c SHALL be the carry out; for SUB and CMP, flag_c SHALL be 1 when A < B unsigned (borrow); for all other ops, flag_c SHALL be 0.
REQ-023 flag_z SHALL be 1 when the REG_WIDTH-bit result is 0; for CMP, result SHALL hold A-B.
REQ-024 Latency from the accept edge SHALL be: WRITE in cycle +3 for two-operand ops, cycle +2 for MOV, cycle +1 for LDI; the register file is updated at the end of that cycle.
REQ-025 Throughput SHALL be one instruction per 4/3/2 cycles; in_valid while busy SHALL be ignored and the fields need not be held after the accept.
REQ-026 rd equal to rs1 or rs2 SHALL be legal: operands are read before the write, so the old value is used.
REQ-027 An instruction offered during the WRITE cycle SHALL NOT be accepted; it is accepted in the following IDLE cycle.

Reset
REQ-028 While reset is high at a rising edge, the state SHALL become IDLE and the latched fields, operands, result, flag_z and flag_c SHALL become 0.
REQ-029 While reset is high, in_valid SHALL be ignored, rf_write_enable SHALL be 0 and done SHALL be 0.
REQ-030 Reset asserted mid-instruction, including during WRITE, SHALL abort it: no register file write occurs at that edge and no done pulse follows.

Verification
REQ-031 Preload r1=0x7F, r2=0x81; ADD rd=3, rs1=1, rs2=2 -> done 3 cycles after accept; r3=0x00, flag_z=1, flag_c=1.
REQ-032 r1=0x05, r2=0x07; SUB rd=4 -> r4=0xFE, flag_c=1, flag_z=0; CMP rs1=2, rs2=2 -> no write, flag_z=1, flag_c=0, result=0x00.
REQ-033 LDI rd=5, imm=0xA5 -> write in cycle +1 with rf_wreg_index=5, data 0xA5; then MOV rd=6, rs1=5 -> r6=0xA5 at cycle +2; no read of rs2 occurs.
REQ-034 r2=0x0F; XOR rd=2, rs1=2, rs2=2 -> r2=0x00, flag_z=1 (aliasing uses the old value).
REQ-035 Back-to-back stream of 3 ADDs with in_valid held high -> accepts exactly every 4 cycles, in_ready low in READ_A/READ_B/WRITE, 3 done pulses.
REQ-036 Reset pulsed in the READ_B cycle of ADD rd=7 -> r7 unchanged, no done, in_ready=1 the cycle after reset deasserts, and flags read 0.
